// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit instruction words from the I-cache read
// port into a small prefetch queue and hands them to the IR on request
// (single-cycle ir_write strobe with ir_data/ir_pc). Redirects flush the queue.
// Optional feature macro: FETCH_PREFETCH_EN
//   defined     -> run ahead, issuing reads while the queue has a free slot
//   not defined -> demand fetch, one read per outstanding request
`ifndef OPCODE_NOP
`define OPCODE_NOP 4'h0
`endif

module instr_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = {`OPCODE_NOP, 12'h000}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_req,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        i_readM,
    output logic [15:0] i_address,
    input  logic [15:0] i_data,
    input  logic        i_ready,
    output logic        ir_write,
    output logic [15:0] ir_data,
    output logic [15:0] ir_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   addr_q, addr_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ir_write_q, ir_write_d;
    logic [15:0]   ir_data_q, ir_data_d;
    logic [15:0]   ir_pc_q, ir_pc_d;

    // Each entry holds {pc, instruction word}
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   head;

    logic          pend;
    logic          q_empty;
    logic          issue_ok;
    logic          issue;
    logic          push;
    logic          pop;

    // A request seen this cycle counts as pending straight away, which gives
    // the one-cycle ir_req -> ir_write latency when a word is already queued.
    assign pend    = pending_q | ir_req;
    assign q_empty = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];

`ifdef FETCH_PREFETCH_EN
    // In IDLE nothing is outstanding, so a free slot is the only condition.
    assign issue_ok = (count_q < CW'(DEPTH));
`else
    // Demand fetch: only go to memory when someone is waiting and nothing is queued.
    assign issue_ok = pend && q_empty;
`endif

    assign issue = (state_q == S_IDLE) && !redirect && issue_ok;
    // Redirect drops any returning data, including data arriving in the same cycle.
    assign push  = (state_q == S_REQ) && i_ready && !redirect;
    // Head is read from registered storage, so a word pushed this edge is not
    // visible until the next one (no push->pop bypass).
    assign pop   = !redirect && pend && !q_empty;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: a redirect during a read turns it into a discard
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the read stays asserted, with a held address, through a discard
    always_comb begin
        i_readM   = (state_q != S_IDLE);
        i_address = addr_q;
    end

    // Datapath next-state: fetch pointer, queue bookkeeping, delivery register
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pending_d  = pend && !pop;
        ir_write_d = pop;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;

        if (issue) begin
            addr_d = fetch_pc_q;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 16'd1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                ir_pc_d   = head[31:16];
                ir_data_d = head[15:0];
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            pending_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ir_write_q <= 1'b0;
            ir_data_q  <= NOP_WORD;
            ir_pc_q    <= 16'h0000;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ir_write_q <= ir_write_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    // Queue storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fetch_pc_q, i_data};
        end
    end

    assign ir_write = ir_write_q;
    assign ir_data  = ir_data_q;
    assign ir_pc    = ir_pc_q;

endmodule
